// File: rtl/stack_memory_stage_if.sv
// Request/response bundle between the pipeline and the data-memory stage.
interface stack_memory_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic                  req;
    logic                  mem_read;
    logic                  mem_write;
    logic                  sp_or_alu_res;
    logic [1:0]            sp_operation;
    logic                  wide;
    logic [2*DATA_W-1:0]   reg_src;
    logic [DATA_W-1:0]     data_result;
    logic [2*DATA_W-1:0]   data;
    logic                  rd_valid;
    logic                  busy;
    logic [ADDR_W-1:0]     sp_value;
    logic                  stack_fault;

    modport master (
        output req, mem_read, mem_write, sp_or_alu_res, sp_operation, wide, reg_src, data_result,
        input  data, rd_valid, busy, sp_value, stack_fault
    );

    modport slave (
        input  req, mem_read, mem_write, sp_or_alu_res, sp_operation, wide, reg_src, data_result,
        output data, rd_valid, busy, sp_value, stack_fault
    );
endinterface

// File: rtl/stack_memory_stage.sv
// Data-memory stage: single-port RAM with integrated stack pointer and two-beat wide accesses.
// Define SP_BOUNDS_CHECK_EN to reject pushes below SP_LIMIT and pops above SP_INIT.
module stack_memory_stage #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 12,
    parameter int unsigned SP_INIT  = 2**ADDR_W-1,
    parameter int unsigned SP_LIMIT = 0
) (
    input logic                 clk,
    input logic                 rst,
    stack_memory_stage_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    typedef enum logic {IDLE, BEAT2} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sp_q, sp_d, sp2_q, sp2_d, addr2_q, addr2_d;
    logic [DATA_W-1:0]   wdata2_q, wdata2_d, lo_q, lo_d;
    logic                wr2_q, wr2_d;
    logic [2*DATA_W-1:0] data_q, data_d;
    logic                rd_valid_q, rd_valid_d, busy_q, busy_d;

    logic                is_wr, is_rd, push, pop, reject;
    logic [ADDR_W-1:0]   base, a1, a2, sp_new, ram_addr;
    logic [DATA_W-1:0]   src_lo, src_hi, w1, w2, ram_rdata, ram_wdata;
    logic                ram_we;

    assign is_wr  = bus.mem_write;
    assign is_rd  = bus.mem_read & ~bus.mem_write;
    assign push   = ~bus.sp_or_alu_res & (bus.sp_operation == 2'b01) & is_wr;
    assign pop    = ~bus.sp_or_alu_res & (bus.sp_operation == 2'b10) & is_rd;
    assign src_lo = bus.reg_src[DATA_W-1:0];
    assign src_hi = bus.reg_src[2*DATA_W-1:DATA_W];
    assign base   = bus.sp_or_alu_res ? bus.data_result[ADDR_W-1:0] : sp_q;

    // Pushes walk downward (high word first); everything else walks upward from a1.
    assign a1     = pop ? sp_q + ONE : base;
    assign a2     = push ? sp_q - ONE : a1 + ONE;
    assign w1     = (push & bus.wide) ? src_hi : src_lo;
    assign w2     = push ? src_lo : src_hi;
    assign sp_new = push ? sp_q - (bus.wide ? TWO : ONE) :
                    pop  ? sp_q + (bus.wide ? TWO : ONE) : sp_q;

`ifdef SP_BOUNDS_CHECK_EN
    localparam logic [ADDR_W+1:0] LIMIT_X = (ADDR_W+2)'(SP_LIMIT);
    localparam logic [ADDR_W+1:0] INIT_X  = (ADDR_W+2)'(SP_INIT);
    logic [ADDR_W+1:0] sp_x, step_x;
    logic              stack_fault_q, stack_fault_d;

    assign sp_x   = {2'b00, sp_q};
    assign step_x = bus.wide ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1);
    // Lowest word a push touches is SP-step+1; a pop leaves SP at SP+step.
    assign reject = (push & ((sp_x + (ADDR_W+2)'(1)) < (LIMIT_X + step_x))) |
                    (pop  & ((sp_x + step_x) > INIT_X));
    assign stack_fault_d = (state_q == IDLE) & bus.req & reject;

    always_ff @(posedge clk) begin
        if (!rst) stack_fault_q <= 1'b0;
        else      stack_fault_q <= stack_fault_d;
    end
    assign bus.stack_fault = stack_fault_q;
`else
    wire unused_limit = |SP_LIMIT;
    assign reject          = 1'b0;
    assign bus.stack_fault = 1'b0;
`endif

    wire unused_dr = ^bus.data_result;

    assign ram_rdata = mem[ram_addr];

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        sp2_d      = sp2_q;
        addr2_d    = addr2_q;
        wdata2_d   = wdata2_q;
        wr2_d      = wr2_q;
        lo_d       = lo_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        ram_addr   = a1;
        ram_we     = 1'b0;
        ram_wdata  = w1;
        case (state_q)
            IDLE: begin
                if (bus.req && (is_wr || is_rd) && !reject) begin
                    ram_we = is_wr;
                    if (!bus.wide) begin
                        sp_d = sp_new;
                        if (is_rd) begin
                            data_d     = {{DATA_W{1'b0}}, ram_rdata};
                            rd_valid_d = 1'b1;
                        end
                    end else begin
                        state_d  = BEAT2;
                        addr2_d  = a2;
                        wdata2_d = w2;
                        wr2_d    = is_wr;
                        sp2_d    = sp_new;
                        lo_d     = ram_rdata;
                    end
                end
            end
            BEAT2: begin
                ram_addr  = addr2_q;
                ram_we    = wr2_q;
                ram_wdata = wdata2_q;
                sp_d      = sp2_q;
                state_d   = IDLE;
                if (!wr2_q) begin
                    data_d     = {ram_rdata, lo_q};
                    rd_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BEAT2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sp_q       <= ADDR_W'(SP_INIT);
            sp2_q      <= '0;
            addr2_q    <= '0;
            wdata2_q   <= '0;
            wr2_q      <= 1'b0;
            lo_q       <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            sp2_q      <= sp2_d;
            addr2_q    <= addr2_d;
            wdata2_q   <= wdata2_d;
            wr2_q      <= wr2_d;
            lo_q       <= lo_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    // RAM is not cleared by reset; a reset edge only suppresses the write on that edge.
    always_ff @(posedge clk) begin
        if (rst && ram_we) mem[ram_addr] <= ram_wdata;
    end

    assign bus.data     = data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.sp_value = sp_q;
endmodule

// File: tb/tb_stack_memory_stage.sv
// Scoreboard bench for stack_memory_stage: stimulus queues expected reads, a negedge monitor checks them.
module tb_stack_memory_stage;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_memory_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
    stack_memory_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && bus.rd_valid) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rd_valid_unexpected: data=%h cyc=%0d, required no read", bus.data, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.data !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL read_data: got %h at cyc %0d, required %h at cyc %0d",
                             bus.data, cyc, e.data, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    // One access; xr=1 queues exp_v as the read expected 1 (narrow) or 2 (wide) cycles later.
    task automatic acc(input logic rd, input logic wr, input logic alu, input logic [1:0] op,
                       input logic wd, input logic [31:0] src, input logic [15:0] addr,
                       input logic xr, input logic [31:0] exp_v);
        exp_t e;
        bus.req = 1'b1; bus.mem_read = rd; bus.mem_write = wr; bus.sp_or_alu_res = alu;
        bus.sp_operation = op; bus.wide = wd; bus.reg_src = src; bus.data_result = addr;
        if (xr) begin
            e.data = exp_v;
            e.due  = cyc + (wd ? 2 : 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.req = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        if (wd) begin
            chk("busy_beat2", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req = 0; bus.mem_read = 0; bus.mem_write = 0; bus.sp_or_alu_res = 0;
        bus.sp_operation = 2'b00; bus.wide = 0; bus.reg_src = '0; bus.data_result = '0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sp", 32'(bus.sp_value), 32'd4095);
        chk("rst_data", bus.data, 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fault", 32'(bus.stack_fault), 32'd0);
        rst = 1'b1;

        // ALU narrow write/read, upper data_result bits ignored
        acc(0, 1, 1, 2'b00, 0, 32'h0000BEEF, 16'h0010, 0, 0);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0010, 1, 32'h0000BEEF);
        acc(1, 0, 1, 2'b00, 0, 0, 16'hF010, 1, 32'h0000BEEF);

        // ALU wide write wrapping past the top of memory
        acc(0, 1, 1, 2'b00, 1, 32'hAAAA5555, 16'h0FFF, 0, 0);
        acc(1, 0, 1, 2'b00, 1, 0, 16'h0FFF, 1, 32'hAAAA5555);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0000, 1, 32'h0000AAAA);
        chk("alu_sp_unchanged", 32'(bus.sp_value), 32'd4095);

        // Narrow push/pop
        acc(0, 1, 0, 2'b01, 0, 32'h00001234, 0, 0, 0);
        chk("push_sp", 32'(bus.sp_value), 32'd4094);
        acc(1, 0, 0, 2'b10, 0, 0, 0, 1, 32'h00001234);
        chk("pop_sp", 32'(bus.sp_value), 32'd4095);

        // Wide push/pop
        acc(0, 1, 0, 2'b01, 1, 32'hCAFE0001, 0, 0, 0);
        chk("wpush_sp", 32'(bus.sp_value), 32'd4093);
        acc(1, 0, 0, 2'b10, 1, 0, 0, 1, 32'hCAFE0001);
        chk("wpop_sp", 32'(bus.sp_value), 32'd4095);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0FFF, 1, 32'h0000CAFE);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0FFE, 1, 32'h00000001);

        // Peek at SP, write-wins-over-read, empty request
        acc(1, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0000CAFE);
        chk("peek_sp", 32'(bus.sp_value), 32'd4095);
        acc(1, 1, 1, 2'b00, 0, 32'h00007777, 16'h0020, 0, 0);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0020, 1, 32'h00007777);
        acc(0, 0, 0, 2'b01, 0, 32'h00009999, 0, 0, 0);
        chk("noop_sp", 32'(bus.sp_value), 32'd4095);

        // Reset during BEAT2 of a wide push
        bus.req = 1; bus.mem_read = 0; bus.mem_write = 1; bus.sp_or_alu_res = 0;
        bus.sp_operation = 2'b01; bus.wide = 1; bus.reg_src = 32'h11112222;
        @(posedge clk); #1;
        bus.req = 0; bus.mem_write = 0;
        chk("abort_busy_mid", 32'(bus.busy), 32'd1);
        chk("abort_sp_mid", 32'(bus.sp_value), 32'd4095);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_sp", 32'(bus.sp_value), 32'd4095);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0FFE, 1, 32'h00000001);
        acc(1, 0, 1, 2'b00, 0, 0, 16'h0FFF, 1, 32'h00001111);

        // Pop at the stack top
`ifdef SP_BOUNDS_CHECK_EN
        acc(1, 0, 0, 2'b10, 0, 0, 0, 0, 0);
        chk("bound_fault", 32'(bus.stack_fault), 32'd1);
        chk("bound_sp", 32'(bus.sp_value), 32'd4095);
        @(posedge clk); #1;
        chk("bound_fault_pulse", 32'(bus.stack_fault), 32'd0);
`else
        acc(1, 0, 0, 2'b10, 0, 0, 0, 1, 32'h0000AAAA);
        chk("wrap_sp", 32'(bus.sp_value), 32'd0);
        chk("wrap_fault", 32'(bus.stack_fault), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stack_memory_stage.md
Name: stack_memory_stage

Overview:
- Parametrised data-memory stage for the pipelined core: synchronous single-port data RAM plus an integrated stack pointer.
- Serves ALU-addressed loads/stores and SP-addressed push/pop.
- Adds two-beat wide (2×DATA_W) accesses for CALL/RET/INT PC+flags save.
- Registered read with valid strobe; busy output stalls the pipeline during the second beat.

Parameters:
- DATA_W, 16, memory word width in bits.
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words.
- SP_INIT, 2**ADDR_W-1, stack pointer value after reset (stack top, grows down).
- SP_LIMIT, 0, lowest legal stack address (used only by optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- req  in  1  access request strobe; accepted when busy=0.
- mem_read  in  1  read access.
- mem_write  in  1  write access; wins over mem_read when both are 1.
- sp_or_alu_res  in  1  1 = address from data_result; 0 = address from SP.
- sp_operation  in  2  00 none, 01 push, 10 pop, 11 none.
- wide  in  1  1 = two-word access.
- reg_src  in  2*DATA_W  write data; low DATA_W bits used when wide=0.
- data_result  in  DATA_W  ALU address; low ADDR_W bits used.
- data  out  2*DATA_W  read data; high half zero on narrow reads.
- rd_valid  out  1  one-cycle pulse when data is updated.
- busy  out  1  high while the second beat is pending.
- sp_value  out  ADDR_W  current registered SP.
- stack_fault  out  1  see Optional Feature.

Behaviour:
- Reset (rst=0 at a clk edge):
  - SP←SP_INIT, FSM←IDLE.
  - data←0, rd_valid←0, busy←0, stack_fault←0.
  - RAM contents are not cleared.
- FSM states IDLE and BEAT2.
  - IDLE: accepts req. Narrow access completes at the accept edge. Wide access goes to BEAT2 and sets busy=1.
  - BEAT2: performs the second word, then returns to IDLE with busy=0.
  - req while busy=1 is ignored; the requester holds its request.
- Access type:
  - mem_read=mem_write=0 with req=1: no memory access and no SP change.
  - Both mem_read and mem_write set: treated as a write, no rd_valid.
- ALU-addressed accesses (sp_or_alu_res=1):
  - Word at A = data_result[ADDR_W-1:0].
  - Wide: low word at A, high word at (A+1) mod DEPTH.
  - sp_operation is ignored and SP is unchanged.
- SP-addressed accesses (sp_or_alu_res=0):
  - Push (01 with write):
    - Narrow: M[SP]←low; SP←SP-1.
    - Wide: beat1 M[SP]←high, beat2 M[SP-1]←low; SP←SP-2, applied at the BEAT2 edge.
  - Pop (10 with read):
    - Narrow: SP←SP+1; data←M[SP+1].
    - Wide: beat1 reads low at SP+1, beat2 reads high at SP+2; SP←SP+2 at the BEAT2 edge.
  - sp_operation 00/11, or a push/pop mismatched with the access type: peek/poke at SP with SP unchanged.
- Arithmetic: all address and SP arithmetic is modulo 2**ADDR_W (silent wrap).
- Read latency:
  - Narrow: data and rd_valid=1 in the cycle after the accept edge.
  - Wide: data and rd_valid in the cycle after the BEAT2 edge, i.e. 2 cycles after accept; data updates only once, with both halves.
  - data holds its value between reads.
- Writes are committed at the clock edge of their beat.
- Reset during BEAT2 aborts the access:
  - The second beat is not performed.
  - SP←SP_INIT, no rd_valid.
  - The first-beat write stays in RAM.

Optional Feature:
- Macro SP_BOUNDS_CHECK_EN.
- When defined:
  - A push that would write below SP_LIMIT is rejected before any beat: no RAM write, SP unchanged, FSM stays in IDLE.
  - A pop that would move SP above SP_INIT is rejected the same way: no read, no rd_valid, SP unchanged, FSM stays in IDLE.
  - On rejection, stack_fault pulses high for 1 cycle.
- When not defined: stack_fault is tied to 0 and SP wraps silently.

Test Plan (default parameters):
- Reset: rst=0 for one edge -> sp_value=4095, data=0, rd_valid=0, busy=0.
- ALU write: 0xBEEF to data_result=0x0010, then a narrow read of 0x0010 -> data=0x0000BEEF with rd_valid 1 cycle after accept.
- Narrow stack: push 0x1234 -> M[4095]=0x1234, sp_value=4094. Then pop -> sp_value=4095, data=0x00001234.
- Wide push: 0xCAFE0001 -> busy=1 for one cycle, M[4095]=0xCAFE, M[4094]=0x0001, sp_value=4093. Wide pop -> data=0xCAFE0001 with rd_valid 2 cycles after accept, sp_value=4095.
- Reset mid-operation: rst=0 during BEAT2 of a wide push of 0x11112222 -> M[4094] unchanged, sp_value=4095, busy=0.
- Bounds: narrow pop at sp_value=4095.
  - With SP_BOUNDS_CHECK_EN: stack_fault=1 for 1 cycle, sp_value=4095, no rd_valid.
  - Without it: sp_value=0, data=M[0].
